// File: rtl/visframe_rx.sv
// Frame buffer between a correlator visibility stream and a back-pressured AXI-Stream consumer.
// Whole frames are committed atomically. Define VISRX_COUNTERS_EN to enable the drop counter.
module visframe_rx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CBITS = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     vis_frame_i,
    input  logic                     vis_valid_i,
    input  logic                     vis_first_i,
    input  logic                     vis_last_i,
    input  logic [WIDTH-1:0]         vis_real_i,
    input  logic [WIDTH-1:0]         vis_imag_i,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic [2*WIDTH-1:0]       m_tdata,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CBITS-1:0]         drop_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] cm_ptr_q, cm_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] fe_ptr_q;
    logic [PW-1:0] base_ptr;
    logic          has_space;
    logic          wr_en;
    logic          start;
    logic          drop_proto;
    logic          drop_ovf;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] s1_data_q;
    logic          s1_valid_q;
    logic          out_ready;
    logic          fetch;
    logic          xfer;

    // A new first word inside an open frame reuses the space of the abandoned partial frame.
    always_comb begin
        base_ptr   = (state_q == StRecv && vis_first_i) ? cm_ptr_q : wr_ptr_q;
        has_space  = (base_ptr - rd_ptr_q) != PW'(DEPTH);
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        wr_en      = 1'b0;
        start      = 1'b0;
        drop_proto = 1'b0;
        drop_ovf   = 1'b0;
        if (vis_valid_i) begin
            case (state_q)
                StIdle: begin
                    if (vis_first_i) start = 1'b1;
                    else             drop_proto = 1'b1;
                end
                StRecv: begin
                    if (vis_first_i) begin
                        drop_proto = 1'b1;
                        wr_ptr_d   = cm_ptr_q;
                        start      = 1'b1;
                    end else if (!has_space) begin
                        wr_ptr_d = cm_ptr_q;
                        drop_ovf = 1'b1;
                        state_d  = vis_last_i ? StIdle : StDrop;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (vis_last_i) begin
                            cm_ptr_d = wr_ptr_q + PW'(1);
                            state_d  = StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (vis_first_i)     start = 1'b1;
                    else if (vis_last_i) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            if (start) begin
                if (!has_space) begin
                    wr_ptr_d = cm_ptr_q;
                    drop_ovf = 1'b1;
                    state_d  = vis_last_i ? StIdle : StDrop;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = base_ptr + PW'(1);
                    if (vis_last_i) begin
                        cm_ptr_d = base_ptr + PW'(1);
                        state_d  = StIdle;
                    end else begin
                        state_d  = StRecv;
                    end
                end
            end
        end else if (state_q == StRecv && !vis_frame_i) begin
            wr_ptr_d   = cm_ptr_q;
            drop_proto = 1'b1;
            state_d    = StIdle;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            overflow_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            overflow_o <= drop_ovf;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[base_ptr[AW-1:0]] <= {vis_last_i, vis_imag_i, vis_real_i};
    end

    // rd_ptr frees space only on consumer transfer; fe_ptr runs ahead to fill the read pipeline.
    assign out_ready = !m_tvalid || m_tready;
    assign fetch     = (fe_ptr_q != cm_ptr_q) && (!s1_valid_q || out_ready);
    assign xfer      = m_tvalid && m_tready;
    assign rd_ptr_d  = rd_ptr_q + PW'(xfer);

    always_ff @(posedge clock) begin
        if (fetch) s1_data_q <= mem[fe_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fe_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            m_tdata    <= '0;
            level_o    <= '0;
        end else begin
            if (fetch) begin
                s1_valid_q <= 1'b1;
                fe_ptr_q   <= fe_ptr_q + PW'(1);
            end else if (out_ready) begin
                s1_valid_q <= 1'b0;
            end
            if (out_ready) begin
                m_tvalid <= s1_valid_q;
                if (s1_valid_q) {m_tlast, m_tdata} <= s1_data_q;
            end
            rd_ptr_q <= rd_ptr_d;
            level_o  <= cm_ptr_d - rd_ptr_d;
        end
    end

`ifdef VISRX_COUNTERS_EN
    logic [CBITS:0] drop_sum;
    assign drop_sum = {1'b0, drop_count_o} + (CBITS+1)'(drop_proto) + (CBITS+1)'(drop_ovf);

    always_ff @(posedge clock) begin
        if (reset)            drop_count_o <= '0;
        else if (drop_sum[CBITS]) drop_count_o <= '1;
        else                  drop_count_o <= drop_sum[CBITS-1:0];
    end
`else
    logic unused_drop;
    assign unused_drop  = drop_proto;
    assign drop_count_o = '0;
`endif

endmodule
